// File: rtl/alu_exec_unit.sv
// Registered execute unit: RV32I/RV64I register-ALU ops plus iterative
// MUL/DIVU/REMU behind valid/ready handshakes on both sides.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_SLL, K_SLT,
    K_SLTU, K_XOR, K_SRL, K_SRA,
    K_OR, K_AND, K_MUL, K_DIVU,
    K_REMU, K_ILL
  } kind_t;

  state_t          r_state;
  state_t          w_state_nx;
  kind_t           w_kind;
  kind_t           r_mkind;
  logic            w_m;
  logic            w_is_m;
  logic            w_acc;
  logic            w_last;
  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_base;
  logic [SW-1:0]   r_cnt;
  logic [XLEN-1:0] r_opa;
  logic [XLEN-1:0] r_opb;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;
  logic [XLEN-1:0] w_mul_acc;
  logic [XLEN:0]   w_rs;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_mres;
  logic            w_unused;

  // only the R-type bit of the opcode matters here
  assign w_unused = ^{op[6], op[4:0]};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

  assign w_acc   = in_valid && in_ready;
  assign w_m     = op[5] && (funct7 == 7'b0000001);
  assign w_shamt = b[SW-1:0];
  assign w_last  = (r_cnt == SW'(XLEN - 1));

  always_comb begin
    w_kind = K_ILL;
    unique case (aluop)
      2'b00: w_kind = K_ADD;
      2'b01: w_kind = K_SUB;
      2'b11: w_kind = K_ILL;
      2'b10: begin
        if (w_m) begin
          if (ENABLE_M) begin
            unique case (funct3)
              3'b000:  w_kind = K_MUL;
              3'b101:  w_kind = K_DIVU;
              3'b111:  w_kind = K_REMU;
              default: w_kind = K_ILL;
            endcase
          end
        end else begin
          unique case (funct3)
            3'b000: w_kind = (op[5] && funct7[5]) ? K_SUB : K_ADD;
            3'b001: w_kind = K_SLL;
            3'b010: w_kind = K_SLT;
            3'b011: w_kind = K_SLTU;
            3'b100: w_kind = K_XOR;
            3'b101: w_kind = funct7[5] ? K_SRA : K_SRL;
            3'b110: w_kind = K_OR;
            3'b111: w_kind = K_AND;
          endcase
        end
      end
    endcase
  end

  assign w_is_m = (w_kind == K_MUL) || (w_kind == K_DIVU)
               || (w_kind == K_REMU);

  always_comb begin
    w_base = '0;
    unique case (w_kind)
      K_ADD:   w_base = a + b;
      K_SUB:   w_base = a - b;
      K_SLL:   w_base = a << w_shamt;
      K_SLT:   w_base = XLEN'($signed(a) < $signed(b));
      K_SLTU:  w_base = XLEN'(a < b);
      K_XOR:   w_base = a ^ b;
      K_SRL:   w_base = a >> w_shamt;
      K_SRA:   w_base = $signed(a) >>> w_shamt;
      K_OR:    w_base = a | b;
      K_AND:   w_base = a & b;
      default: w_base = '0;
    endcase
  end

  // r_opa is the shifted multiplicand for MUL and the dividend/quotient
  // shift register for division; r_acc is product or partial remainder
  assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);
  assign w_rs      = {r_acc, r_opa[XLEN-1]};
  assign w_ge      = (w_rs >= {1'b0, r_opb});
  assign w_diff    = w_rs[XLEN-1:0] - r_opb;
  assign w_rem_nx  = w_ge ? w_diff : w_rs[XLEN-1:0];
  assign w_quo_nx  = {r_opa[XLEN-2:0], w_ge};

  always_comb begin
    w_mres = w_rem_nx;
    if (r_mkind == K_MUL)
      w_mres = w_mul_acc;
    else if (r_mkind == K_DIVU)
      w_mres = w_quo_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_acc)
          w_state_nx = w_is_m ? S_BUSY : S_DONE;
      S_BUSY:
        if (w_last)
          w_state_nx = S_DONE;
      S_DONE:
        if (out_ready)
          w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_mkind   <= K_ADD;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_opa   <= a;
            r_opb   <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mkind <= w_kind;
            if (!w_is_m) begin
              r_result  <= w_base;
              r_zero    <= (w_base == '0);
              r_illegal <= (w_kind == K_ILL);
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + SW'(1);
          if (r_mkind == K_MUL) begin
            r_acc <= w_mul_acc;
            r_opa <= r_opa << 1;
            r_opb <= r_opb >> 1;
          end else begin
            r_acc <= w_rem_nx;
            r_opa <= w_quo_nx;
          end
          if (w_last) begin
            r_result  <= w_mres;
            r_zero    <= (w_mres == '0);
            r_illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: XLEN=32 with and without M ops.
module tb_alu_exec_unit;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_S = 7'b0100000;
  localparam logic [6:0] F7_M = 7'b0000001;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        il;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  aluop = 2'b00;
  logic [6:0]  op = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [6:0]  funct7 = 7'b0;
  logic [31:0] a = 32'b0;
  logic [31:0] b = 32'b0;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;

  logic        nm_in_valid = 1'b0;
  logic        nm_out_ready = 1'b0;
  logic        nm_in_ready, nm_out_valid, nm_zero, nm_illegal;
  logic [31:0] nm_result;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .op(op), .funct3(funct3), .funct7(funct7),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n),
    .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .aluop(aluop), .op(op), .funct3(funct3), .funct7(funct7),
    .a(a), .b(b),
    .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .result(nm_result), .zero(nm_zero), .illegal(nm_illegal)
  );

  task automatic push(input logic [31:0] r, input logic il, input int lat);
    exp_t e;
    e.r = r;
    e.z = (r == 32'd0);
    e.il = il;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic send(input logic [1:0] ao, input logic [6:0] o,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] x, input logic [31:0] y);
    int w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    aluop = ao; op = o; funct3 = f3; funct7 = f7; a = x; b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // waits for out_valid, captures it, then retires it; lat counts edges
  task automatic finish_op(output logic [31:0] r, output logic z,
                           output logic il, output int lat);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    lat = out_valid ? n + 1 : -1;
    r = result; z = zero; il = illegal;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({in_ready, out_valid, result, zero, illegal} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b il=%b want 1 0 0 0 0",
               in_ready, out_valid, result, zero, illegal);
    end
    send(2'b10, OP_R, 3'b101, F7_M, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 32'd0}) begin
      n_errors++;
      $display("FAIL reset_mid_divu: got rdy=%b vld=%b res=%h want 1 0 0",
               in_ready, out_valid, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_no_result: got vld=%b want 0", out_valid);
    end
  endtask

  task automatic run_table(input string name, input int n,
                           input logic [1:0] ao[], input logic [6:0] o[],
                           input logic [2:0] f3[], input logic [6:0] f7[],
                           input logic [31:0] x[], input logic [31:0] y[],
                           input logic [31:0] er[], input logic eil[],
                           input int elat);
    logic [31:0] r;
    logic z, il;
    int lat;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      push(er[i], eil[i], elat);
      send(ao[i], o[i], f3[i], f7[i], x[i], y[i]);
      finish_op(r, z, il, lat);
      e = sb.pop_front();
      n_checks++;
      if ({r, z, il} !== {e.r, e.z, e.il} || lat != e.lat) begin
        n_errors++;
        $display("FAIL %s[%0d]: got res=%h z=%b il=%b lat=%0d want res=%h z=%b il=%b lat=%0d",
                 name, i, r, z, il, lat, e.r, e.z, e.il, e.lat);
      end
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL %s_retire[%0d]: got vld=%b rdy=%b want 0 1",
                 name, i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_sub;
    run_table("sub", 2,
      '{2'b10, 2'b10}, '{OP_R, OP_R}, '{3'b000, 3'b000}, '{F7_S, F7_S},
      '{32'd5, 32'd9}, '{32'd7, 32'd9},
      '{32'hFFFF_FFFE, 32'd0}, '{1'b0, 1'b0}, 1);
  endtask

  task automatic test_shift;
    run_table("shift", 3,
      '{2'b10, 2'b10, 2'b10}, '{OP_R, OP_R, OP_R},
      '{3'b101, 3'b101, 3'b001}, '{F7_S, F7_0, F7_0},
      '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
      '{32'h21, 32'h21, 32'h21},
      '{32'hC000_0000, 32'h4000_0000, 32'd0}, '{1'b0, 1'b0, 1'b0}, 1);
  endtask

  task automatic test_alu_misc;
    run_table("alu", 8,
      '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10},
      '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_I, OP_R},
      '{3'b000, 3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b000, 3'b010},
      '{F7_0, F7_0, F7_0, F7_0, F7_0, F7_0, F7_S, F7_0},
      '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h1234_5678, 32'hF000_000F, 32'd10, 32'd3},
      '{32'd2, 32'd1, 32'd1, 32'd1,
        32'hFFFF_0000, 32'h0F00_0F00, 32'h20, 32'hFFFF_FFFF},
      '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0,
        32'hEDCB_5678, 32'hFF00_0F0F, 32'd42, 32'd0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1);
  endtask

  task automatic test_mul;
    logic [31:0] r;
    logic z, il;
    int lat, n, busy, dummy;
    exp_t e;
    push(32'hFFFF_FFFD, 1'b0, 33);
    send(2'b10, OP_R, 3'b000, F7_M, 32'hFFFF_FFFF, 32'd3);
    n = 0; busy = 0;
    while (!out_valid && n < 200) begin
      if (!in_ready) busy++;
      @(posedge clk); #1; n++;
    end
    lat = out_valid ? n + 1 : -1;
    finish_op(r, z, il, dummy);
    e = sb.pop_front();
    n_checks++;
    if ({r, z, il} !== {e.r, e.z, e.il} || lat != e.lat || busy != 32) begin
      n_errors++;
      $display("FAIL mul_neg: got res=%h z=%b il=%b lat=%0d busy=%0d want res=%h z=%b il=%b lat=%0d busy=32",
               r, z, il, lat, busy, e.r, e.z, e.il, e.lat);
    end
    run_table("mul", 2,
      '{2'b10, 2'b10}, '{OP_R, OP_R}, '{3'b000, 3'b000}, '{F7_M, F7_M},
      '{32'd12345, 32'h0001_0000}, '{32'd6789, 32'h0001_0000},
      '{32'd83810205, 32'd0}, '{1'b0, 1'b0}, 33);
  endtask

  task automatic test_div;
    run_table("div", 5,
      '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10},
      '{OP_R, OP_R, OP_R, OP_R, OP_R},
      '{3'b101, 3'b111, 3'b101, 3'b111, 3'b101},
      '{F7_M, F7_M, F7_M, F7_M, F7_M},
      '{32'd100, 32'd100, 32'd100, 32'd100, 32'hFFFF_FFFF},
      '{32'd7, 32'd7, 32'd0, 32'd0, 32'h8000_0000},
      '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd100, 32'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 33);
  endtask

  task automatic test_backpressure;
    logic [31:0] r;
    logic z, il;
    int lat, bad;
    exp_t e;
    push(32'hF000_F000, 1'b0, 1);
    send(2'b10, OP_R, 3'b111, F7_0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    e = sb.pop_front();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      if (!out_valid || result !== e.r || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL backpressure_hold: got %0d unstable cycles want 0", bad);
    end
    finish_op(r, z, il, lat);
    n_checks++;
    if ({r, z, il} !== {e.r, e.z, e.il} || lat != 1) begin
      n_errors++;
      $display("FAIL backpressure_res: got res=%h z=%b il=%b lat=%0d want res=%h z=%b il=%b lat=1",
               r, z, il, lat, e.r, e.z, e.il);
    end
  endtask

  task automatic test_illegal;
    run_table("illegal", 2,
      '{2'b11, 2'b10}, '{OP_R, OP_R}, '{3'b000, 3'b010}, '{F7_0, F7_M},
      '{32'd5, 32'd5}, '{32'd7, 32'd7},
      '{32'd0, 32'd0}, '{1'b1, 1'b1}, 1);
  endtask

  task automatic test_no_m;
    int n = 0;
    aluop = 2'b10; op = OP_R; funct3 = 3'b000; funct7 = F7_M;
    a = 32'd6; b = 32'd7;
    nm_in_valid = 1'b1;
    @(posedge clk); #1;
    nm_in_valid = 1'b0;
    while (!nm_out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if ({nm_out_valid, nm_illegal, nm_result} !== {1'b1, 1'b1, 32'd0} || n != 0) begin
      n_errors++;
      $display("FAIL no_m_mul: got vld=%b il=%b res=%h wait=%0d want 1 1 0 wait=0",
               nm_out_valid, nm_illegal, nm_result, n);
    end
    nm_out_ready = 1'b1;
    @(posedge clk); #1;
    nm_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic z, il;
    int lat;
    exp_t e;
    push(32'd30, 1'b0, 1);
    push(32'd42, 1'b0, 33);
    push(32'd3, 1'b0, 1);
    send(2'b00, OP_R, 3'b000, F7_0, 32'd10, 32'd20);
    for (int i = 0; i < 3; i++) begin
      finish_op(r, z, il, lat);
      e = sb.pop_front();
      n_checks++;
      if ({r, z, il} !== {e.r, e.z, e.il} || lat != e.lat) begin
        n_errors++;
        $display("FAIL b2b[%0d]: got res=%h lat=%0d want res=%h lat=%0d",
                 i, r, lat, e.r, e.lat);
      end
      if (i == 0) send(2'b10, OP_R, 3'b000, F7_M, 32'd6, 32'd7);
      if (i == 1) send(2'b10, OP_R, 3'b100, F7_0, 32'd5, 32'd6);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_sub();
    test_shift();
    test_alu_misc();
    test_mul();
    test_div();
    test_backpressure();
    test_illegal();
    test_no_m();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Registered, handshaked execute unit for the RISC-V core. It is the successor to the combinational ALU-control decoder: it decodes aluop/op/funct3/funct7 internally and covers the full RV32I/RV64I register-ALU set. It also adds optional iterative M-extension ops (MUL, DIVU, REMU) behind a valid/ready handshake. It sits between the register-file read stage and write-back.

Parameters:
XLEN, 32, operand/result width (32 or 64).
ENABLE_M, 1, 1 = MUL/DIVU/REMU implemented; 0 = those encodings flagged illegal.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept (high only in IDLE)
aluop  in  2  00 add, 01 sub, 10 decode funct fields, 11 reserved
op  in  7  opcode (only op[5] used: 1 = R-type)
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
a  in  XLEN  operand A
b  in  XLEN  operand B / immediate
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result
zero  out  1  result == 0
illegal  out  1  decoded encoding unsupported (result = 0)

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1, out_valid=0, result=0, zero=0 (flag registered with result, cleared on reset), illegal=0; iteration counter and accumulators cleared. Reset mid-operation aborts it and drops the result.
- Accept: in_valid && in_ready at a rising edge. Operands and decode are captured on that edge.
- Decode (m = op[5] && funct7==7'b0000001):
  - aluop 00: ADD.
  - aluop 01: SUB.
  - aluop 11: illegal.
  - aluop 10, !m, by funct3:
    - 000: SUB if op[5]&funct7[5], else ADD.
    - 001: SLL.
    - 010: SLT (signed).
    - 011: SLTU.
    - 100: XOR.
    - 101: SRA if funct7[5], else SRL.
    - 110: OR.
    - 111: AND.
  - aluop 10, m, ENABLE_M=1, by funct3: 000 MUL (low XLEN bits); 101 DIVU; 111 REMU; any other funct3 is illegal. With ENABLE_M=0, all m encodings are illegal.
- Arithmetic rules:
  - Add/sub wrap modulo 2^XLEN.
  - Shift amount = b[$clog2(XLEN)-1:0].
  - SLT/SLTU results are 0 or 1, zero-extended.
- States:
  - IDLE: on accept of a base or illegal op, go to DONE with result computed; latency 1 cycle (out_valid high the cycle after accept). On accept of an M op, go to BUSY with counter=0.
  - BUSY: in_ready=0. MUL is shift-add, one bit of b per cycle. DIVU/REMU are restoring division, one quotient bit per cycle. After exactly XLEN cycles, go to DONE. Total latency from accept to out_valid is XLEN+1 cycles.
  - DONE: out_valid=1. result, zero and illegal are held stable until out_valid && out_ready; then go to IDLE. in_ready=0 in DONE, so there is no back-to-back accept in the same cycle as output retire.
- Divide by zero (b==0): DIVU gives all ones, REMU gives a. These take the same XLEN-cycle latency; not illegal.
- in_valid while in BUSY/DONE is ignored; operand changes after accept have no effect.
- out_ready while not in DONE is ignored.

Test Plan:
- Reset mid-DIVU (rst_n low at BUSY cycle 5) -> next cycle in_ready=1, out_valid=0, result=0.
- aluop=10, op[5]=1, funct7=0100000, funct3=000, a=5, b=7 -> one cycle later out_valid=1, result=32'hFFFF_FFFE, zero=0. Same with a=b=9 -> result=0, zero=1.
- Shifts, XLEN=32, a=32'h8000_0000, b=32'h21:
  - funct3=101, funct7[5]=1 -> result=32'hC000_0000.
  - funct7[5]=0 -> 32'h4000_0000.
  - funct3=001 -> 0.
- MUL a=32'hFFFF_FFFF, b=3 -> in_ready low for 32 cycles, out_valid at accept+33, result=32'hFFFF_FFFD.
- DIVU a=100, b=7 -> result 14; REMU -> 2; DIVU b=0 -> 32'hFFFF_FFFF; REMU b=0 -> 100.
- Backpressure: hold out_ready=0 for 10 cycles after an AND result -> out_valid and result stable, in_ready=0. aluop=11 -> illegal=1, result=0. ENABLE_M=0 build with MUL encoding -> illegal=1 with 1-cycle latency.
